// File: rtl/aes_sbox.sv
// Registered AES forward S-box: out_byte = affine(inv(in_byte)) one clock after in_valid.
// The inverse is x^254 in GF(2^8), so no 256-entry table has to be maintained by hand.
module aes_sbox (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    output logic [7:0] out_byte
);

    // Handshake: a byte is accepted on every rising edge where in_valid=1 (no ready,
    // no stall); out_valid follows in_valid one cycle later and out_byte holds between results.

    // Shift-and-add multiply with reduction by x^8+x^4+x^3+x+1 at each step.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; this yields 0 for x=0, as required.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    logic [7:0] sub_byte;

    always_comb begin
        sub_byte = affine(gf_inv(in_byte));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out_byte <= sub_byte;
        end
    end

endmodule

// File: tb/tb_aes_sbox.sv
// Bench for aes_sbox: directed vectors, exhaustive sweep, hold/gap checks and a
// randomized stream scored against a search-based GF(2^8) reference model.
module tb_aes_sbox;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       out_valid;
    logic [7:0] out_byte;

    logic       lane_valid;
    logic [7:0] lane_byte [1:3];
    logic       lane_ov   [1:3];
    logic [7:0] lane_out  [1:3];

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ref_sbox [256];
    logic [7:0] exp_q [$];

    aes_sbox u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .out_valid(out_valid),
        .out_byte (out_byte)
    );

    aes_sbox u_lane1 (.clk(clk), .rst_n(rst_n), .in_valid(lane_valid), .in_byte(lane_byte[1]),
                      .out_valid(lane_ov[1]), .out_byte(lane_out[1]));
    aes_sbox u_lane2 (.clk(clk), .rst_n(rst_n), .in_valid(lane_valid), .in_byte(lane_byte[2]),
                      .out_valid(lane_ov[2]), .out_byte(lane_out[2]));
    aes_sbox u_lane3 (.clk(clk), .rst_n(rst_n), .in_valid(lane_valid), .in_byte(lane_byte[3]),
                      .out_valid(lane_ov[3]), .out_byte(lane_out[3]));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: full polynomial product then reduction, inverse by search,
    // affine transform bit by bit as b'_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_sub(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] r;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            r[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                 ^ inv[(i + 7) % 8] ^ c[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Driver: apply inputs, take one edge, sample 1 time unit later.
    task automatic drive(input logic v, input logic [7:0] b);
        in_valid = v;
        in_byte  = b;
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  spot_in  [7] = '{8'h00, 8'h01, 8'h53, 8'hC9, 8'hCF, 8'hFF, 8'h10};
    logic [7:0]  spot_out [7] = '{8'h63, 8'h7C, 8'hED, 8'hDD, 8'h8A, 8'h16, 8'hCA};
    logic [31:0] sw_in    [2] = '{32'hCF4F3C09, 32'h14DFF409};
    logic [31:0] sw_out   [2] = '{32'h8A84EB01, 32'hFA9EBF01};
    logic [4:0]  gap_v    = 5'b01101;
    logic [7:0]  gap_b    [5] = '{8'h01, 8'h00, 8'h02, 8'h03, 8'h00};
    logic [7:0]  gap_o    [5] = '{8'h7C, 8'h7C, 8'h77, 8'h7B, 8'h7B};

    initial begin
        logic [255:0] seen;
        int           run;
        int           distinct;
        logic [7:0]   held;
        logic [31:0]  w;
        logic [7:0]   e;
        logic         v;
        logic [7:0]   b;

        for (int i = 0; i < 256; i++) ref_sbox[i] = ref_sub(8'(i));
        rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        lane_valid = 1'b0; lane_byte[1] = 8'h00; lane_byte[2] = 8'h00; lane_byte[3] = 8'h00;

        // Reset held with valid input driven
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h53);
            chk("rst_hold_valid", 32'(out_valid), 32'h0);
            chk("rst_hold_byte", 32'(out_byte), 32'h00);
        end
        rst_n = 1'b1;

        // Model self-check plus spot values
        for (int i = 0; i < 7; i++) begin
            chk("ref_model_spot", 32'(ref_sbox[spot_in[i]]), 32'(spot_out[i]));
            drive(1'b1, spot_in[i]);
            chk("spot_valid", 32'(out_valid), 32'h1);
            chk("spot_byte", 32'(out_byte), 32'(spot_out[i]));
        end

        // Asynchronous reset mid-cycle after a valid result
        drive(1'b1, 8'h53);
        chk("pre_async_byte", 32'(out_byte), 32'hED);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_byte", 32'(out_byte), 32'h00);
        #1 rst_n = 1'b1;
        drive(1'b1, 8'h01);
        chk("first_after_rst", 32'(out_byte), 32'h7C);

        // SubWord composition across four lanes
        for (int k = 0; k < 2; k++) begin
            lane_valid   = 1'b1;
            lane_byte[1] = sw_in[k][15:8];
            lane_byte[2] = sw_in[k][23:16];
            lane_byte[3] = sw_in[k][31:24];
            drive(1'b1, sw_in[k][7:0]);
            w = {lane_out[3], lane_out[2], lane_out[1], out_byte};
            chk("subword", w, sw_out[k]);
            chk("subword_valid", 32'({lane_ov[3], lane_ov[2], lane_ov[1], out_valid}), 32'hF);
        end
        lane_valid = 1'b0;

        // Exhaustive back-to-back sweep
        seen = '0; run = 0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 8'(i));
            if (out_valid) run++;
            seen[out_byte] = 1'b1;
            chk("exhaustive", 32'(out_byte), 32'(ref_sbox[i]));
        end
        chk("exhaustive_run", 32'(run), 32'd256);
        distinct = 0;
        for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
        chk("exhaustive_distinct", 32'(distinct), 32'd256);

        // Hold with random don't-care bytes
        drive(1'b1, 8'h53);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'($urandom_range(0, 255)));
            chk("hold_valid", 32'(out_valid), 32'h0);
            chk("hold_byte", 32'(out_byte), 32'hED);
        end

        // Gapped stream
        for (int i = 0; i < 5; i++) begin
            drive(gap_v[i], gap_b[i]);
            chk("gap_valid", 32'(out_valid), 32'(gap_v[i]));
            chk("gap_byte", 32'(out_byte), 32'(gap_o[i]));
        end

        // Randomized stream scored through the expected queue
        held = 8'h7B;
        for (int i = 0; i < 300; i++) begin
            v = 1'($urandom_range(0, 1));
            b = 8'($urandom_range(0, 255));
            if (v) held = ref_sbox[b];
            exp_q.push_back(held);
            drive(v, b);
            e = exp_q.pop_front();
            chk("rand_valid", 32'(out_valid), 32'(v));
            chk("rand_byte", 32'(out_byte), 32'(e));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
